tipi_nibble_bus_master: RTL and testbench

- Byte-level master that sequences the TIPI 4-bit nibble bus (`tipi_4bit_pi_bus` slave).
- Turns a single req/ack transaction into a bus reset pulse, a register-select nibble, then two data nibbles, high nibble first.
- Generates the bus strobe from the system clock. The data bus is split into data_o, oe and data_i; the tristate buffer sits at the top level.
- Used for board bring-up and as the Pi-side model in integration sims.

---
 rtl/tipi_nibble_bus_master.sv | 95 +++++++++
 tb/tb_tipi_nibble_bus_master.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tipi_nibble_bus_master.sv
// tipi_nibble_bus_master: sequences one req/ack byte transaction onto the TIPI 4-bit nibble bus
// (bus reset pulse, select nibble, then two data nibbles high first).
module tipi_nibble_bus_master #(
   parameter int HALF_CYCLES = 2,
   parameter int CNT_W = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic       we,
   input  logic [1:0] sel,
   input  logic [7:0] wdata,
   output logic       ack,
   output logic       err,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       bus_clk,
   output logic       bus_reset,
   output logic [3:0] bus_data_o,
   output logic       bus_data_oe,
   input  logic [3:0] bus_data_i
);
   typedef enum logic [3:0] {
      IDLE, RST_HI, RST_LO, SEL_SU, SEL_HI, SEL_LO,
      W_SU, W_HI, W_LO, TURN, R_HI, R_LO, DONE
   } state_t;
   state_t state, state_n;
   logic [CNT_W-1:0] cnt;
   logic last, legal, we_q, nib, nib_n;
   logic [1:0] sel_q;
   logic [7:0] wdata_q;
   logic [3:0] rhi;
   assign last = cnt == '0;
   // writes target RD/RC (sel[1]=1), reads target TD/TC (sel[1]=0)
   assign legal = we == sel[1];
   assign nib_n = state == IDLE ? 1'b1 : (state == W_LO && last) ? 1'b0 : nib;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = !req ? IDLE : legal ? RST_HI : DONE;
         RST_HI:  if (last) state_n = RST_LO;
         RST_LO:  if (last) state_n = SEL_SU;
         SEL_SU:  if (last) state_n = SEL_HI;
         SEL_HI:  if (last) state_n = SEL_LO;
         SEL_LO:  if (last) state_n = we_q ? W_SU : TURN;
         W_SU:    if (last) state_n = W_HI;
         W_HI:    if (last) state_n = W_LO;
         W_LO:    if (last) state_n = nib ? W_SU : DONE;
         TURN:    if (last) state_n = R_HI;
         R_HI:    if (last) state_n = R_LO;
         R_LO:    if (last) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // outputs are registered from the next state so they switch together with it
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         nib         <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= 2'd0;
         wdata_q     <= 8'h00;
         rhi         <= 4'h0;
         ack         <= 1'b0;
         err         <= 1'b0;
         rdata       <= 8'h00;
         busy        <= 1'b0;
         bus_clk     <= 1'b0;
         bus_reset   <= 1'b0;
         bus_data_o  <= 4'h0;
         bus_data_oe <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= state_n != state ? CNT_W'(HALF_CYCLES - 1) : cnt - CNT_W'(1);
         nib   <= nib_n;
         if (state == IDLE && req) begin
            we_q    <= we;
            sel_q   <= sel;
            wdata_q <= wdata;
         end
         if (state == TURN && last) rhi <= bus_data_i;
         if (state == R_LO && last) rdata <= {rhi, bus_data_i};
         ack         <= state_n == DONE;
         err         <= state == IDLE && req && !legal;
         busy        <= state_n != IDLE;
         bus_reset   <= state_n == RST_HI;
         bus_clk     <= state_n inside {SEL_HI, W_HI, R_HI};
         bus_data_oe <= state_n inside {SEL_SU, SEL_HI, SEL_LO, W_SU, W_HI, W_LO};
         bus_data_o  <= state_n inside {SEL_SU, SEL_HI, SEL_LO} ? {2'b00, sel_q} :
                        state_n inside {W_SU, W_HI, W_LO} ? (nib_n ? wdata_q[7:4] : wdata_q[3:0]) : 4'h0;
      end
   end
endmodule

// File: tb/tb_tipi_nibble_bus_master.sv
// tb_tipi_nibble_bus_master: two masters (HALF_CYCLES=2 and 1), each wired to a behavioural
// nibble-bus slave; vector table plus hand-written multi-cycle sequences.
module tb_tipi_nibble_bus_master;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       rst[2], req[2], we[2], ack[2], err[2], busy[2], bclk[2], brst[2], oe[2];
   logic [1:0] sel[2];
   logic [7:0] wdata[2], rdata[2], td[2], tc[2];
   logic [3:0] dout[2], din[2], pdo[2];
   int errors = 0, checks = 0;

   for (genvar g = 0; g < 2; g++) begin : gi
      logic [1:0] scnt, ssel;
      logic [3:0] shi;
      logic       pb;
      logic [7:0] srd, src, sval;
      logic       sdrv;
      tipi_nibble_bus_master #(.HALF_CYCLES(g == 0 ? 2 : 1), .CNT_W(8)) dut (
         .clk(clk), .reset(rst[g]), .req(req[g]), .we(we[g]), .sel(sel[g]), .wdata(wdata[g]),
         .ack(ack[g]), .err(err[g]), .rdata(rdata[g]), .busy(busy[g]), .bus_clk(bclk[g]),
         .bus_reset(brst[g]), .bus_data_o(dout[g]), .bus_data_oe(oe[g]), .bus_data_i(din[g]));
      assign sval = ssel[0] ? tc[g] : td[g];
      assign sdrv = scnt != 2'd0 && scnt != 2'd3 && !ssel[1];
      assign din[g] = oe[g] ? dout[g] : sdrv ? (scnt == 2'd1 ? sval[7:4] : sval[3:0]) : 4'hF;
      // slave: nibble 0 selects the register, then two data nibbles on bus_clk rises
      always @(posedge clk) begin
         pb <= bclk[g];
         if (brst[g]) scnt <= 2'd0;
         else if (bclk[g] && !pb) begin
            if (scnt == 2'd0) begin
               ssel <= din[g][1:0];
               scnt <= 2'd1;
            end else if (scnt == 2'd1) begin
               shi  <= din[g];
               scnt <= 2'd2;
            end else if (scnt == 2'd2) begin
               if (ssel == 2'd2) srd <= {shi, din[g]};
               if (ssel == 2'd3) src <= {shi, din[g]};
               scnt <= 2'd3;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // every cycle: bus rules on both instances
   task automatic tick();
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         if (!rst[g]) begin
            chk("clk_reset_overlap", {31'd0, bclk[g] & brst[g]}, 0);
            chk("oe_during_reset", {31'd0, oe[g] & brst[g]}, 0);
            chk("data_stable_clk_high", {31'd0, bclk[g] && dout[g] != pdo[g]}, 0);
         end
         pdo[g] = dout[g];
      end
   endtask

   task automatic txn(input int g, input logic w, input logic [1:0] s, input logic [7:0] d, output int lat);
      we[g] = w;
      sel[g] = s;
      wdata[g] = d;
      req[g] = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
         if (lat == 1) req[g] = 1'b0;
      end while (!ack[g] && lat < 200);
   endtask

   typedef struct {
      logic       w;
      logic [1:0] s;
      logic [7:0] d;
      logic [7:0] preset;
      int         lat;
      logic       e;
      logic [7:0] rd;
      logic [7:0] slv;
   } vec_t;
   vec_t v[6];

   initial begin
      int lat, n, acks;
      v[0] = '{1'b0, 2'd0, 8'h00, 8'hA5, 17, 1'b0, 8'hA5, 8'h00};
      v[1] = '{1'b0, 2'd1, 8'h00, 8'h5A, 17, 1'b0, 8'h5A, 8'h00};
      v[2] = '{1'b1, 2'd2, 8'hA5, 8'h00, 23, 1'b0, 8'h5A, 8'hA5};
      v[3] = '{1'b1, 2'd3, 8'h5A, 8'h00, 23, 1'b0, 8'h5A, 8'h5A};
      v[4] = '{1'b1, 2'd0, 8'hFF, 8'h00, 1, 1'b1, 8'h5A, 8'h00};
      v[5] = '{1'b0, 2'd3, 8'hFF, 8'h00, 1, 1'b1, 8'h5A, 8'h00};
      for (int g = 0; g < 2; g++) begin
         rst[g] = 1'b1;
         req[g] = 1'b0;
         we[g] = 1'b0;
         sel[g] = 2'd0;
         wdata[g] = 8'h00;
         td[g] = 8'h00;
         tc[g] = 8'h00;
         pdo[g] = 4'h0;
      end
      repeat (3) tick();
      chk("reset_outputs", {14'd0, ack[0], err[0], rdata[0], busy[0], bclk[0], brst[0], dout[0], oe[0]}, 0);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) begin
         if (!v[i].w && v[i].s == 2'd0) td[0] = v[i].preset;
         if (!v[i].w && v[i].s == 2'd1) tc[0] = v[i].preset;
         txn(0, v[i].w, v[i].s, v[i].d, lat);
         chk($sformatf("v%0d_latency", i), lat, v[i].lat);
         chk($sformatf("v%0d_err", i), {31'd0, err[0]}, {31'd0, v[i].e});
         chk($sformatf("v%0d_rdata", i), {24'd0, rdata[0]}, {24'd0, v[i].rd});
         chk($sformatf("v%0d_busy_at_ack", i), {31'd0, busy[0]}, 1);
         if (v[i].e) chk($sformatf("v%0d_no_bus", i), {29'd0, brst[0], bclk[0], oe[0]}, 0);
         if (v[i].w && !v[i].e)
            chk($sformatf("v%0d_slave_reg", i), {24'd0, v[i].s == 2'd2 ? gi[0].srd : gi[0].src}, {24'd0, v[i].slv});
         tick();
         chk($sformatf("v%0d_busy_after", i), {30'd0, busy[0], ack[0]}, 0);
      end
      // back-to-back reads with req held high
      td[0] = 8'h3C;
      tc[0] = 8'hC3;
      we[0] = 1'b0;
      sel[0] = 2'd0;
      req[0] = 1'b1;
      lat = 0;
      do begin tick(); lat++; end while (!ack[0] && lat < 200);
      chk("b2b_first_latency", lat, 17);
      chk("b2b_first_rdata", {24'd0, rdata[0]}, 32'h3C);
      sel[0] = 2'd1;
      n = 0;
      do begin tick(); n++; end while (!ack[0] && n < 200);
      chk("b2b_second_gap", n, 18);
      chk("b2b_second_rdata", {24'd0, rdata[0]}, 32'hC3);
      req[0] = 1'b0;
      acks = 0;
      repeat (30) begin tick(); acks += int'(ack[0]); end
      chk("b2b_no_extra_ack", acks, 0);
      // reset during the high-nibble W_HI of a write
      we[0] = 1'b1;
      sel[0] = 2'd2;
      wdata[0] = 8'h3F;
      req[0] = 1'b1;
      tick();
      req[0] = 1'b0;
      repeat (12) tick();
      chk("abort_in_w_hi", {30'd0, bclk[0], oe[0]}, 3);
      rst[0] = 1'b1;
      tick();
      chk("abort_reset_outputs", {14'd0, ack[0], err[0], rdata[0], busy[0], bclk[0], brst[0], dout[0], oe[0]}, 0);
      rst[0] = 1'b0;
      acks = 0;
      repeat (30) begin tick(); acks += int'(ack[0]); end
      chk("abort_no_ack", acks, 0);
      chk("abort_slave_untouched", {24'd0, gi[0].srd}, 32'hA5);
      txn(0, 1'b1, 2'd2, 8'h81, lat);
      chk("after_abort_latency", lat, 23);
      chk("after_abort_slave_rd", {24'd0, gi[0].srd}, 32'h81);
      // HALF_CYCLES=1 instance
      td[1] = 8'h96;
      txn(1, 1'b0, 2'd0, 8'h00, lat);
      chk("h1_latency", lat, 9);
      chk("h1_err", {31'd0, err[1]}, 0);
      chk("h1_rdata", {24'd0, rdata[1]}, 32'h96);
      tick();
      chk("h1_busy_after", {31'd0, busy[1]}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
